// File: rtl/div_pkg.sv
// Shared definitions for the sequential divide unit: FSM states, counter sizing
// and the fixed quotient returned for a zero divisor.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    DONE
  } div_state_e;

  localparam logic [63:0] DIV_ZERO_Q = '1;

  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the
// divisor from the widened remainder and keep the difference when it does not borrow.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   dvsr_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] trial;

  // The bit shifted out of the remainder is kept as the trial's top bit.
  always_comb begin
    trial = acc_i[2*WIDTH-1:WIDTH-1] - {1'b0, dvsr_i};
    if (!trial[WIDTH]) begin
      acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
    end else begin
      acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned restoring divider with Run/Rdy handshake.
// Works on magnitudes and restores the result signs in the FIX state.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             Run,
  input  logic             Signed,
  input  logic [WIDTH-1:0] Dvnd,
  input  logic [WIDTH-1:0] Dvsr,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             Rdy,
  output logic             Busy,
  output logic             DivZero
);

  localparam int CW = cnt_width(WIDTH);

  div_state_e         state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   dvsr_q;
  logic               dvnd_neg_q;
  logic               dvsr_neg_q;
  logic               zero_q;

  logic               dvnd_neg;
  logic               dvsr_neg;
  logic [WIDTH-1:0]   dvnd_mag;
  logic [WIDTH-1:0]   dvsr_mag;
  logic [WIDTH-1:0]   rem_sel;

  assign dvnd_neg = Signed & Dvnd[WIDTH-1];
  assign dvsr_neg = Signed & Dvsr[WIDTH-1];
  assign dvnd_mag = dvnd_neg ? -Dvnd : Dvnd;
  assign dvsr_mag = dvsr_neg ? -Dvsr : Dvsr;

  // A zero divisor skips ITER, so the dividend magnitude is still in the low half
  // and re-applying its sign returns the original dividend as the remainder.
  assign rem_sel = zero_q ? acc_q[WIDTH-1:0] : acc_q[2*WIDTH-1:WIDTH];

  div_step #(.WIDTH(WIDTH)) u_step (
    .acc_i (acc_q),
    .dvsr_i(dvsr_q),
    .acc_o (acc_d)
  );

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      dvsr_q     <= '0;
      dvnd_neg_q <= 1'b0;
      dvsr_neg_q <= 1'b0;
      zero_q     <= 1'b0;
      Q          <= '0;
      R          <= '0;
      Rdy        <= 1'b0;
      Busy       <= 1'b0;
      DivZero    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (Run) begin
            dvnd_neg_q <= dvnd_neg;
            dvsr_neg_q <= dvsr_neg;
            zero_q     <= (Dvsr == '0);
            acc_q      <= {{WIDTH{1'b0}}, dvnd_mag};
            dvsr_q     <= dvsr_mag;
            cnt_q      <= '0;
            Rdy        <= 1'b0;
            Busy       <= 1'b1;
            DivZero    <= 1'b0;
            state_q    <= (Dvsr == '0) ? FIX : ITER;
          end
        end
        ITER: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          // Overflow needs no special case: the magnitude quotient wraps to -2^(W-1).
          if (zero_q) begin
            Q <= DIV_ZERO_Q[WIDTH-1:0];
          end else begin
            Q <= (dvnd_neg_q ^ dvsr_neg_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          end
          R       <= dvnd_neg_q ? -rem_sel : rem_sel;
          Rdy     <= 1'b1;
          Busy    <= 1'b0;
          DivZero <= zero_q;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
